// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order register write-back FIFO merging MEM and ALU results, with decode bypass
module reg_writeback_queue #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_mem_valid,
    output logic                      o_mem_ready,
    input  logic [ADDR_W-1:0]         i_mem_addr,
    input  logic [WIDTH-1:0]          i_mem_data,
    input  logic                      i_alu_valid,
    output logic                      o_alu_ready,
    input  logic [ADDR_W-1:0]         i_alu_addr,
    input  logic [WIDTH-1:0]          i_alu_data,
    input  logic [ADDR_W-1:0]         i_ra,
    input  logic [ADDR_W-1:0]         i_rb,
    output logic                      o_fwd_a_hit,
    output logic [WIDTH-1:0]          o_fwd_a,
    output logic                      o_fwd_b_hit,
    output logic [WIDTH-1:0]          o_fwd_b,
    output logic                      o_writeEnable,
    output logic [ADDR_W-1:0]         o_writeAddr,
    output logic [WIDTH-1:0]          o_d,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [WIDTH-1:0]  r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_mem_push;
    logic              w_alu_push;
    logic              w_pop;
    logic [PW-1:0]     w_alu_slot;
    logic [WIDTH:0]    w_fwd_a;
    logic [WIDTH:0]    w_fwd_b;

    // Readiness looks only at the registered count, so it never depends on the same-cycle pop.
    assign o_mem_ready = (r_count <= CW'(DEPTH - 1));
    assign o_alu_ready = (r_count <= CW'(DEPTH - 2));
    assign w_mem_push  = i_mem_valid && o_mem_ready;
    assign w_alu_push  = i_alu_valid && o_alu_ready;
    assign w_pop       = (r_count != '0);
    // The ALU entry lands behind the MEM entry when both arrive together.
    assign w_alu_slot  = r_tail + PW'(w_mem_push);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_mem_push) + PW'(w_alu_push);
            r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_mem_push) begin
            r_addr[r_tail] <= i_mem_addr;
            r_data[r_tail] <= i_mem_data;
        end
        if (!i_reset && w_alu_push) begin
            r_addr[w_alu_slot] <= i_alu_addr;
            r_data[w_alu_slot] <= i_alu_data;
        end
    end

    // Walk occupied entries oldest to youngest so the last match (youngest) is what remains.
    function automatic logic [WIDTH:0] lookup(input logic [ADDR_W-1:0] a);
        logic [WIDTH:0] res;
        logic [PW-1:0]  idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[idx] == a)) begin
                res = {1'b1, r_data[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_fwd_a = lookup(i_ra);
        w_fwd_b = lookup(i_rb);
    end

    assign o_fwd_a_hit   = w_fwd_a[WIDTH];
    assign o_fwd_a       = w_fwd_a[WIDTH-1:0];
    assign o_fwd_b_hit   = w_fwd_b[WIDTH];
    assign o_fwd_b       = w_fwd_b[WIDTH-1:0];
    assign o_writeEnable = w_pop;
    assign o_writeAddr   = w_pop ? r_addr[r_head] : '0;
    assign o_d           = w_pop ? r_data[r_head] : '0;
    assign o_count       = r_count;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - randomized self-checking bench for reg_writeback_queue against a queue model
module tb_reg_writeback_queue;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int NREG   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_valid, alu_valid;
    logic              mem_ready, alu_ready;
    logic [ADDR_W-1:0] mem_addr, alu_addr, ra, rb;
    logic [WIDTH-1:0]  mem_data, alu_data;
    logic              fwd_a_hit, fwd_b_hit, we;
    logic [WIDTH-1:0]  fwd_a, fwd_b, wd;
    logic [ADDR_W-1:0] wa;
    logic [CW-1:0]     count;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
    } ent_t;

    ent_t             q[$];
    logic [WIDTH-1:0] m_rf [NREG] = '{default: '0};
    logic [WIDTH-1:0] d_rf [NREG] = '{default: '0};
    int               n_checks = 0;
    int               n_fail   = 0;

    reg_writeback_queue #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_addr(mem_addr), .i_mem_data(mem_data),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_addr(alu_addr), .i_alu_data(alu_data),
        .i_ra(ra), .i_rb(rb),
        .o_fwd_a_hit(fwd_a_hit), .o_fwd_a(fwd_a), .o_fwd_b_hit(fwd_b_hit), .o_fwd_b(fwd_b),
        .o_writeEnable(we), .o_writeAddr(wa), .o_d(wd), .o_count(count)
    );

    always #5 clk = ~clk;

    // Shadow register_file fed only by what the DUT presents on its write port.
    always @(posedge clk) begin
        if (!reset && we) d_rf[wa] <= wd;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] model_fwd(input logic [ADDR_W-1:0] a);
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (q[j].a == a) return {1'b1, q[j].d};
        end
        return '0;
    endfunction

    task automatic step(input logic rst,
                        input logic mv, input logic [ADDR_W-1:0] ma, input logic [WIDTH-1:0] md,
                        input logic av, input logic [ADDR_W-1:0] aa, input logic [WIDTH-1:0] ad,
                        input logic [ADDR_W-1:0] xa, input logic [ADDR_W-1:0] xb,
                        output logic m_acc, output logic a_acc);
        int             n;
        logic           exp_mr, exp_ar;
        logic [WIDTH:0] fa, fb;
        @(negedge clk);
        reset = rst; mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad; ra = xa; rb = xb;
        #1;
        n      = q.size();
        exp_mr = (n <= DEPTH - 1);
        exp_ar = (n <= DEPTH - 2);
        fa     = model_fwd(xa);
        fb     = model_fwd(xb);
        check_eq("count", 32'(count), 32'(n));
        check_eq("mem_ready", 32'(mem_ready), 32'(exp_mr));
        check_eq("alu_ready", 32'(alu_ready), 32'(exp_ar));
        check_eq("writeEnable", 32'(we), 32'(n > 0));
        check_eq("writeAddr", 32'(wa), (n > 0) ? 32'(q[0].a) : 32'd0);
        check_eq("d", 32'(wd), (n > 0) ? 32'(q[0].d) : 32'd0);
        check_eq("fwd_a_hit", 32'(fwd_a_hit), 32'(fa[WIDTH]));
        check_eq("fwd_a", 32'(fwd_a), 32'(fa[WIDTH-1:0]));
        check_eq("fwd_b_hit", 32'(fwd_b_hit), 32'(fb[WIDTH]));
        check_eq("fwd_b", 32'(fwd_b), 32'(fb[WIDTH-1:0]));
        m_acc = mv && exp_mr;
        a_acc = av && exp_ar;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (n > 0) begin
                m_rf[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (m_acc) q.push_back('{a: ma, d: md});
            if (a_acc) q.push_back('{a: aa, d: ad});
        end
    endtask

    task automatic idle(input logic [ADDR_W-1:0] xa, input logic [ADDR_W-1:0] xb);
        logic ma_, aa_;
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, xa, xb, ma_, aa_);
    endtask

    logic              m_ok, a_ok;
    logic              h_mv, h_av, h_rst;
    logic [ADDR_W-1:0] h_ma, h_aa;
    logic [WIDTH-1:0]  h_md, h_ad;

    initial begin
        reset = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
        mem_addr = '0; alu_addr = '0; mem_data = '0; alu_data = '0; ra = '0; rb = '0;
        repeat (2) @(posedge clk);
        reset = 1'b0;

        idle(3'd0, 3'd0);
        check_eq("reset_count", 32'(count), 32'd0);
        check_eq("reset_mem_ready", 32'(mem_ready), 32'd1);
        check_eq("reset_alu_ready", 32'(alu_ready), 32'd1);

        step(1'b0, 1'b0, '0, '0, 1'b1, 3'd1, 16'h0005, 3'd1, 3'd6, m_ok, a_ok);
        idle(3'd1, 3'd6);
        #1;
        check_eq("rf_r1_after_alu", 32'(d_rf[1]), 32'h0005);

        step(1'b0, 1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 16'h00BB, 3'd2, 3'd7, m_ok, a_ok);
        idle(3'd2, 3'd7);
        idle(3'd2, 3'd7);
        idle(3'd2, 3'd7);
        #1;
        check_eq("rf_r2_younger_wins", 32'(d_rf[2]), 32'h00BB);

        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 3'(i), 16'(i + 16'h100), 1'b1, 3'(i + 1), 16'(i + 16'h200),
                 3'(i), 3'(i + 1), m_ok, a_ok);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 3'(i + 4), 16'(i + 16'h300), 1'b0, '0, '0, 3'(i + 4), 3'd0, m_ok, a_ok);
        for (int i = 0; i < 3; i++) idle(3'(i), 3'(i + 4));

        step(1'b0, 1'b1, 3'd5, 16'hDEAD, 1'b1, 3'd6, 16'hBEEF, 3'd5, 3'd6, m_ok, a_ok);
        step(1'b0, 1'b1, 3'd7, 16'hCAFE, 1'b1, 3'd4, 16'hF00D, 3'd7, 3'd4, m_ok, a_ok);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 3'd7, 3'd4, m_ok, a_ok);
        idle(3'd7, 3'd4);
        check_eq("post_reset_count", 32'(count), 32'd0);
        check_eq("post_reset_we", 32'(we), 32'd0);
        idle(3'd7, 3'd3);

        h_mv = 1'b0; h_av = 1'b0;
        h_ma = '0; h_aa = '0; h_md = '0; h_ad = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!h_mv) begin
                h_mv = ($urandom_range(0, 3) != 0);
                h_ma = ADDR_W'($urandom);
                h_md = WIDTH'($urandom);
            end
            if (!h_av) begin
                h_av = ($urandom_range(0, 3) != 0);
                h_aa = ADDR_W'($urandom);
                h_ad = WIDTH'($urandom);
            end
            h_rst = ($urandom_range(0, 63) == 0);
            step(h_rst, h_mv, h_ma, h_md, h_av, h_aa, h_ad,
                 ADDR_W'($urandom), ADDR_W'($urandom), m_ok, a_ok);
            if (m_ok || h_rst) h_mv = 1'b0;
            if (a_ok || h_rst) h_av = 1'b0;
        end

        for (int i = 0; i < DEPTH + 1; i++) idle(3'(i), 3'(i + 1));
        #1;
        for (int r = 0; r < NREG; r++) check_eq($sformatf("rf_r%0d", r), 32'(d_rf[r]), 32'(m_rf[r]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
